// File: rtl/ctrl_pipe.sv
// Registered instruction decoder: load-use interlock, taken-branch flush and sticky halt/ack.
// Latency: one cycle from accept to out_valid; pgmJmp/flush are combinational from the output register.
// Backpressure: in_ready drops on a full register with out_ready low, on a load-use stall and after halt.
module ctrl_pipe #(
    parameter int OPCDE_W  = 9,
    parameter int OP_W     = 4,
    parameter int PTRA_W   = 3,
    parameter int PTRB_W   = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCDE_W-1:0]       opCde,
    input  logic                     out_ready,
    input  logic                     geFlg,
    input  logic                     neFlg,
    output logic                     out_valid,
    output logic [OP_W-1:0]          pgmOp,
    output logic                     regWrt,
    output logic                     memWrt,
    output logic                     memLd,
    output logic                     lutLd,
    output logic                     imdLd,
    output logic                     pgmJmp,
    output logic                     flush,
    output logic                     ack,
    output logic [PTRA_W-1:0]        opPtrA,
    output logic [PTRB_W-1:0]        opPtrB,
    output logic [PTRA_W+PTRB_W-1:0] opImd
);

    localparam int IMD_W = PTRA_W + PTRB_W;
    localparam int CMP_W = (PTRA_W > PTRB_W) ? PTRA_W : PTRB_W;

    localparam logic [OP_W-1:0] OP_LD0 = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LDR = OP_W'(1);
    localparam logic [OP_W-1:0] OP_STR = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LUT = OP_W'(3);
    localparam logic [OP_W-1:0] OP_CMP = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BRN = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BGE = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BNE = OP_W'(7);

    localparam logic [1:0] STALL_INIT = 2'(LOAD_LAT - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [PTRA_W-1:0] ptr_a;
        logic [PTRB_W-1:0] ptr_b;
        logic [IMD_W-1:0]  imd;
        logic              reg_wrt;
        logic              mem_wrt;
        logic              mem_ld;
        logic              lut_ld;
        logic              imd_ld;
        logic              dne;
    } ctl_t;

    ctl_t       dec;
    ctl_t       ctl_q;
    logic       vld_q;
    state_t     state_q;
    state_t     state_d;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    logic       pgm_jmp;
    logic       ptr_hit;
    logic       hazard;
    logic       in_rdy;
    logic       accept;
    logic       load_word;

    always_comb begin
        dec         = '0;
        dec.op      = opCde[OPCDE_W-1 -: OP_W];
        dec.ptr_b   = opCde[PTRB_W-1:0];
        dec.imd     = opCde[IMD_W-1:0];
        dec.imd_ld  = (dec.op == OP_LD0) || (dec.op == OP_BRN) ||
                      (dec.op == OP_BGE) || (dec.op == OP_BNE);
        dec.lut_ld  = (dec.op == OP_LUT);
        dec.mem_ld  = (dec.op == OP_LDR);
        dec.mem_wrt = (dec.op == OP_STR);
        dec.reg_wrt = !((dec.op == OP_STR) || (dec.op == OP_CMP) || (dec.op == OP_BRN) ||
                        (dec.op == OP_BGE) || (dec.op == OP_BNE));
        // Immediate-form words reuse the A field as immediate bits, so the pointer is suppressed.
        dec.ptr_a   = dec.imd_ld ? '0 : opCde[PTRB_W +: PTRA_W];
        dec.dne     = &opCde;
    end

    assign pgm_jmp = vld_q && ((ctl_q.op == OP_BRN) ||
                               ((ctl_q.op == OP_BGE) && geFlg) ||
                               ((ctl_q.op == OP_BNE) && neFlg));

    assign ptr_hit = (CMP_W'(dec.ptr_a) == CMP_W'(ctl_q.ptr_a)) ||
                     (CMP_W'(dec.ptr_b) == CMP_W'(ctl_q.ptr_a));

    // A word that is about to be flushed never stalls.
    assign hazard = in_valid && vld_q && (ctl_q.op == OP_LDR) &&
                    !dec.imd_ld && !dec.dne && ptr_hit && !pgm_jmp;

    assign in_rdy    = (state_q == ST_RUN) && (!vld_q || out_ready) && !hazard;
    assign accept    = in_valid && in_rdy;
    assign load_word = accept && !pgm_jmp;

    // The hazard cycle itself supplies the first bubble; STALL covers the remaining LOAD_LAT-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (vld_q && ctl_q.dne && out_ready) begin
                    state_d = ST_HALT;
                end else if (hazard && out_ready && (LOAD_LAT > 1)) begin
                    state_d = ST_STALL;
                    cnt_d   = STALL_INIT;
                end
            end
            ST_STALL: begin
                if (out_ready) begin
                    if (cnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_word) begin
                vld_q <= 1'b1;
                ctl_q <= dec;
            end else if (out_ready || !vld_q) begin
                vld_q <= 1'b0;
                ctl_q <= '0;
            end
        end
    end

    assign in_ready  = in_rdy;
    assign out_valid = vld_q;
    assign pgmOp     = ctl_q.op;
    assign regWrt    = ctl_q.reg_wrt;
    assign memWrt    = ctl_q.mem_wrt;
    assign memLd     = ctl_q.mem_ld;
    assign lutLd     = ctl_q.lut_ld;
    assign imdLd     = ctl_q.imd_ld;
    assign opPtrA    = ctl_q.ptr_a;
    assign opPtrB    = ctl_q.ptr_b;
    assign opImd     = ctl_q.imd;
    assign pgmJmp    = pgm_jmp;
    assign flush     = pgm_jmp;
    assign ack       = (state_q == ST_HALT);

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: two instances (LOAD_LAT 1 and 3) checked every cycle against a behavioural model,
// plus directed sequences for decode, interlock, flush, conditional branch, freeze, halt and reset.
module tb_ctrl_pipe;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       out_ready;
    logic       ge_flg;
    logic       ne_flg;
    logic       in_valid  [N];
    logic [8:0] op_cde    [N];
    logic       in_ready  [N];
    logic       out_valid [N];
    logic [3:0] pgm_op    [N];
    logic       reg_wrt   [N];
    logic       mem_wrt   [N];
    logic       mem_ld    [N];
    logic       lut_ld    [N];
    logic       imd_ld    [N];
    logic       pgm_jmp   [N];
    logic       flush     [N];
    logic       ack       [N];
    logic [2:0] op_ptr_a  [N];
    logic [1:0] op_ptr_b  [N];
    logic [4:0] op_imd    [N];

    always #5 clk = ~clk;

    ctrl_pipe #(.OPCDE_W(9), .OP_W(4), .PTRA_W(3), .PTRB_W(2), .LOAD_LAT(1)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .opCde(op_cde[0]), .out_ready(out_ready), .geFlg(ge_flg), .neFlg(ne_flg),
        .out_valid(out_valid[0]), .pgmOp(pgm_op[0]), .regWrt(reg_wrt[0]), .memWrt(mem_wrt[0]),
        .memLd(mem_ld[0]), .lutLd(lut_ld[0]), .imdLd(imd_ld[0]), .pgmJmp(pgm_jmp[0]),
        .flush(flush[0]), .ack(ack[0]), .opPtrA(op_ptr_a[0]), .opPtrB(op_ptr_b[0]),
        .opImd(op_imd[0])
    );

    ctrl_pipe #(.OPCDE_W(9), .OP_W(4), .PTRA_W(3), .PTRB_W(2), .LOAD_LAT(3)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .opCde(op_cde[1]), .out_ready(out_ready), .geFlg(ge_flg), .neFlg(ne_flg),
        .out_valid(out_valid[1]), .pgmOp(pgm_op[1]), .regWrt(reg_wrt[1]), .memWrt(mem_wrt[1]),
        .memLd(mem_ld[1]), .lutLd(lut_ld[1]), .imdLd(imd_ld[1]), .pgmJmp(pgm_jmp[1]),
        .flush(flush[1]), .ack(ack[1]), .opPtrA(op_ptr_a[1]), .opPtrB(op_ptr_b[1]),
        .opImd(op_imd[1])
    );

    int n_vec = 0;
    int n_bad = 0;

    // Fetch side queues and reference model state per instance.
    logic [8:0] fq [N][$];
    int         tr [N][$];
    bit         presented [N];
    bit         mv [N];
    logic [8:0] mw [N];
    bit         halted [N];
    int         owed [N];
    int         jcnt [N];
    int         scnt [N];

    int rdy_mode  = 1;
    bit rnd_valid = 1'b0;
    bit rnd_flags = 1'b0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit is_imd(input int op);
        return (op == 0) || (op == 5) || (op == 6) || (op == 7);
    endfunction

    function automatic bit writes_reg(input int op);
        return !((op == 2) || (op == 4) || (op == 5) || (op == 6) || (op == 7));
    endfunction

    // Field image: op[13:10] ptrA[9:7] ptrB[6:5] imm[4:0]
    function automatic int fld(input logic [8:0] word);
        int w;
        int op;
        int pa;
        w  = int'(word);
        op = w >> 5;
        pa = is_imd(op) ? 0 : ((w >> 2) & 7);
        return (op << 10) | (pa << 7) | ((w & 3) << 5) | (w & 31);
    endfunction

    function automatic int obs_fields(input int k);
        return int'({pgm_op[k], op_ptr_a[k], op_ptr_b[k], op_imd[k]});
    endfunction

    function automatic int trace_at(input int k, input int i);
        int s;
        s = 0;
        while (s < tr[k].size() && tr[k][s] == -1) s++;
        if (s + i < tr[k].size()) return tr[k][s + i];
        return -2;
    endfunction

    function automatic logic [8:0] rand_word();
        int r;
        r = $urandom_range(0, 399);
        if (r == 0) return 9'h1FF;
        if (r < 100) return {4'd1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
        if (r < 160) return {4'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        return 9'($urandom);
    endfunction

    task automatic score(input int k);
        int w;
        int op_i;
        int op_r;
        int pa_r;
        bit jmp;
        bit haz;
        bit busy;
        bit rdy;
        bit acc;
        logic [9:0] ce;
        logic [9:0] co;
        w    = int'(op_cde[k]);
        op_i = w >> 5;
        op_r = int'(mw[k]) >> 5;
        pa_r = (int'(mw[k]) >> 2) & 7;
        jmp  = mv[k] && (op_r == 5 || (op_r == 6 && ge_flg) || (op_r == 7 && ne_flg));
        haz  = in_valid[k] && mv[k] && op_r == 1 && !is_imd(op_i) && w != 511 &&
               (((w >> 2) & 7) == pa_r || (w & 3) == pa_r) && !jmp;
        busy = halted[k] || owed[k] > 0;
        rdy  = !busy && (!mv[k] || out_ready) && !haz;
        acc  = in_valid[k] && rdy;
        ce = {mv[k], mv[k] && writes_reg(op_r), mv[k] && op_r == 2, mv[k] && op_r == 1,
              mv[k] && op_r == 3, mv[k] && is_imd(op_r), jmp, jmp, halted[k], rdy};
        co = {out_valid[k], reg_wrt[k], mem_wrt[k], mem_ld[k], lut_ld[k], imd_ld[k],
              pgm_jmp[k], flush[k], ack[k], in_ready[k]};
        check_val($sformatf("ctl[%0d]", k), int'(co), int'(ce));
        if (mv[k]) check_val($sformatf("fields[%0d]", k), obs_fields(k), fld(mw[k]));
        tr[k].push_back(out_valid[k] ? obs_fields(k) : -1);
        if (pgm_jmp[k]) jcnt[k]++;
        if (in_valid[k] && !in_ready[k]) scnt[k]++;
        // Advance the model across the coming clock edge.
        if (busy) begin
            if (owed[k] > 0 && out_ready) owed[k]--;
        end else if (haz && out_ready) begin
            owed[k] = lat_of(k) - 1;
        end
        if (mv[k] && mw[k] == 9'h1FF && out_ready) halted[k] = 1'b1;
        if (acc && !jmp) begin
            mv[k] = 1'b1;
            mw[k] = op_cde[k];
        end else if (out_ready || !mv[k]) begin
            mv[k] = 1'b0;
            mw[k] = '0;
        end
        if (acc) void'(fq[k].pop_front());
        presented[k] = in_valid[k] && !acc;
    endtask

    task automatic tick();
        @(negedge clk);
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (rnd_flags) begin
            ge_flg = 1'($urandom_range(0, 1));
            ne_flg = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k < N; k++) begin
            if (fq[k].size() > 0 && (presented[k] || !rnd_valid || $urandom_range(0, 4) != 0)) begin
                in_valid[k] = 1'b1;
                op_cde[k]   = fq[k][0];
            end else begin
                in_valid[k] = 1'b0;
                op_cde[k]   = 9'($urandom);
            end
        end
        #1;
        for (int k = 0; k < N; k++) score(k);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) in_valid[k] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < N; k++) begin
            mv[k]        = 1'b0;
            mw[k]        = '0;
            halted[k]    = 1'b0;
            owed[k]      = 0;
            presented[k] = 1'b0;
            fq[k].delete();
        end
    endtask

    task automatic clear_stats();
        for (int k = 0; k < N; k++) begin
            tr[k].delete();
            jcnt[k] = 0;
            scnt[k] = 0;
        end
    endtask

    task automatic push_both(input logic [8:0] w);
        for (int k = 0; k < N; k++) fq[k].push_back(w);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hits;
        reset  = 1'b1;
        ge_flg = 1'b0;
        ne_flg = 1'b0;
        for (int k = 0; k < N; k++) begin
            in_valid[k] = 1'b0;
            op_cde[k]   = '0;
        end
        do_reset();

        // Plain ALU word decode.
        clear_stats();
        push_both(9'h10D);
        repeat (3) tick();
        for (int k = 0; k < N; k++) check_val($sformatf("alu_fields[%0d]", k), trace_at(k, 0), 8621);

        // Load-use interlock: 1 and 3 bubbles.
        do_reset();
        clear_stats();
        push_both(9'h02C);
        push_both(9'h10D);
        repeat (8) tick();
        check_val("ldu1_seq0", trace_at(0, 0), 1420);
        check_val("ldu1_seq1", trace_at(0, 1), -1);
        check_val("ldu1_seq2", trace_at(0, 2), 8621);
        check_val("ldu1_stalls", scnt[0], 1);
        check_val("ldu3_seq0", trace_at(1, 0), 1420);
        check_val("ldu3_seq3", trace_at(1, 3), -1);
        check_val("ldu3_seq4", trace_at(1, 4), 8621);
        check_val("ldu3_stalls", scnt[1], 3);

        // Unconditional branch flushes the following word.
        do_reset();
        clear_stats();
        push_both(9'h0A5);
        push_both(9'h10D);
        repeat (5) tick();
        for (int k = 0; k < N; k++) begin
            hits = 0;
            foreach (tr[k][i]) if (tr[k][i] == 8621) hits++;
            check_val($sformatf("brn_fields[%0d]", k), trace_at(k, 0), 5157);
            check_val($sformatf("brn_jmps[%0d]", k), jcnt[k], 1);
            check_val($sformatf("brn_dropped[%0d]", k), hits, 0);
            check_val($sformatf("brn_fetch_left[%0d]", k), fq[k].size(), 0);
        end

        // Conditional branch, not taken then taken.
        for (int g = 0; g < 2; g++) begin
            do_reset();
            clear_stats();
            ge_flg = g[0];
            push_both(9'h0C2);
            push_both(9'h10D);
            repeat (5) tick();
            check_val($sformatf("bge%0d_fields", g), trace_at(0, 0), 6210);
            check_val($sformatf("bge%0d_next", g), trace_at(0, 1), (g == 0) ? 8621 : -1);
            check_val($sformatf("bge%0d_jmps", g), jcnt[1], g);
        end
        ge_flg = 1'b0;

        // Backpressure freezes the output register.
        do_reset();
        push_both(9'h02C);
        tick();
        clear_stats();
        rdy_mode = 0;
        repeat (3) tick();
        rdy_mode = 1;
        for (int k = 0; k < N; k++) check_val($sformatf("freeze_last[%0d]", k), trace_at(k, 2), 1420);
        repeat (2) tick();

        // Done word halts with a sticky ack.
        do_reset();
        push_both(9'h1FF);
        repeat (2) tick();
        push_both(9'h10D);
        repeat (4) tick();
        for (int k = 0; k < N; k++) begin
            check_val($sformatf("halt_ack[%0d]", k), int'(ack[k]), 1);
            check_val($sformatf("halt_rdy[%0d]", k), int'(in_ready[k]), 0);
            check_val($sformatf("halt_fetch_left[%0d]", k), fq[k].size(), 1);
        end

        // Reset while stalled.
        do_reset();
        push_both(9'h02C);
        push_both(9'h10D);
        repeat (3) tick();
        check_val("stall_rdy", int'(in_ready[1]), 0);
        do_reset();
        tick();
        check_val("post_reset_rdy", int'(in_ready[1]), 1);
        check_val("post_reset_vld", int'(out_valid[1]), 0);

        // Randomized traffic, backpressure and flags.
        rnd_valid = 1'b1;
        rnd_flags = 1'b1;
        rdy_mode  = 2;
        for (int c = 0; c < 2000; c++) begin
            if (c % 250 == 249) do_reset();
            for (int k = 0; k < N; k++) if (fq[k].size() < 2) fq[k].push_back(rand_word());
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
